// File: rtl/ccff_loader_if.sv
// ccff_loader_if: host word channel of the configuration-chain loader.
//
// Signals:
//   word_data  - configuration word, MSB shifted into the chain first
//   word_valid - host has a word on word_data
//   word_ready - loader takes the word on this prog_clk edge
//
// Modports:
//   master - host side (drives data/valid, observes ready)
//   slave  - loader side (observes data/valid, drives ready)

interface ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: host-side driver for the fabric configuration chain (ccff).
//
// Takes configuration words from the host channel and serialises them
// MSB-first onto ccff_head, qualifying each chain shift with ccff_clk_en
// (which gates the chain's prog_clk). With VERIFY_EN set, the chain is then
// recirculated tail->head for one full chain length and a CRC-8 of the
// returned bits is compared with the CRC-8 of the loaded bits.
//
// Ports:
//   prog_clk    - configuration clock, all state on its rising edge
//   pReset      - synchronous active-high reset, wins over everything
//   start       - begin a load (only honoured in IDLE/DONE)
//   abort       - cancel a load/verify in progress
//   word_if     - host word channel (slave side)
//   ccff_head   - serial bit into the chain
//   ccff_clk_en - chain shifts on this edge
//   ccff_tail   - serial bit out of the deepest chain flop
//   busy        - FETCH, SHIFT or VERIFY active
//   done        - load (and verify) finished cleanly or with CRC mismatch
//   error       - CRC mismatch or abort
//   bit_count   - bits shifted in the current pass
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// FETCH  | word_ready high, waiting for the next host word; chain holds
// SHIFT  | shifting the current word onto ccff_head, one bit per edge
// VERIFY | recirculating tail->head, accumulating the readback CRC
// DONE   | finished or aborted; done/error held until the next start

module ccff_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 16,
    parameter int VERIFY_EN = 1,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             start,
    input  logic             abort,
    ccff_loader_if.slave     word_if,
    output logic             ccff_head,
    output logic             ccff_clk_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bit_count
);

    localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [7:0]       CRC_INIT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        crc_tx;
    logic [7:0]        crc_rb;
    logic              word_ready_q;

    // CRC-8, poly x^8+x^2+x+1, one bit per call, MSB-first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign word_if.word_ready = word_ready_q;

    // The head bit must be valid in the same cycle the chain clock is enabled,
    // so it is taken straight from the shift register / recirculated tail.
    always_comb begin
        ccff_head = 1'b0;
        if (state == S_SHIFT) begin
            ccff_head = sreg[WORD_W-1];
        end else if (state == S_VERIFY) begin
            ccff_head = ccff_tail;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state        <= S_IDLE;
            sreg         <= '0;
            idx          <= '0;
            crc_tx       <= CRC_INIT;
            crc_rb       <= CRC_INIT;
            word_ready_q <= 1'b0;
            ccff_clk_en  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bit_count    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_FETCH;
                        bit_count    <= '0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        crc_tx       <= CRC_INIT;
                        crc_rb       <= CRC_INIT;
                        word_ready_q <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (abort) begin
                        state        <= S_DONE;
                        word_ready_q <= 1'b0;
                        ccff_clk_en  <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b0;
                        error        <= 1'b1;
                    end else if (word_if.word_valid) begin
                        state        <= S_SHIFT;
                        sreg         <= word_if.word_data;
                        idx          <= IDX_LAST;
                        word_ready_q <= 1'b0;
                        ccff_clk_en  <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (abort) begin
                        state        <= S_DONE;
                        word_ready_q <= 1'b0;
                        ccff_clk_en  <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b0;
                        error        <= 1'b1;
                    end else begin
                        sreg      <= sreg << 1;
                        bit_count <= bit_count + CNT_W'(1);
                        crc_tx    <= crc8_step(crc_tx, sreg[WORD_W-1]);
                        // Chain full takes priority over word exhaustion: any
                        // bits left in the current word are dropped.
                        if (bit_count == CNT_LAST) begin
                            if (VERIFY_EN != 0) begin
                                state     <= S_VERIFY;
                                bit_count <= '0;
                            end else begin
                                state       <= S_DONE;
                                ccff_clk_en <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                            end
                        end else if (idx == '0) begin
                            state        <= S_FETCH;
                            word_ready_q <= 1'b1;
                            ccff_clk_en  <= 1'b0;
                        end else begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                end

                S_VERIFY: begin
                    if (abort) begin
                        state        <= S_DONE;
                        word_ready_q <= 1'b0;
                        ccff_clk_en  <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b0;
                        error        <= 1'b1;
                    end else begin
                        crc_rb    <= crc8_step(crc_rb, ccff_tail);
                        bit_count <= bit_count + CNT_W'(1);
                        if (bit_count == CNT_LAST) begin
                            // Compare against the CRC including this final bit.
                            state       <= S_DONE;
                            ccff_clk_en <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            error       <= (crc8_step(crc_rb, ccff_tail) != crc_tx);
                        end
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    word_ready_q <= 1'b0;
                    ccff_clk_en  <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    error        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: self-checking bench for ccff_loader.
// Three loaders with different chain lengths / verify settings, each driving
// its own behavioural chain model; one set of host stimulus is steered to the
// selected loader.

module tb_ccff_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       abort;
    logic       word_valid;
    logic [7:0] word_data;
    logic       inject;
    int         sel;

    ccff_loader_if #(.WORD_W(8)) bus_a ();
    ccff_loader_if #(.WORD_W(8)) bus_b ();
    ccff_loader_if #(.WORD_W(8)) bus_c ();

    assign bus_a.word_data  = word_data;
    assign bus_b.word_data  = word_data;
    assign bus_c.word_data  = word_data;
    assign bus_a.word_valid = word_valid && (sel == 0);
    assign bus_b.word_valid = word_valid && (sel == 1);
    assign bus_c.word_valid = word_valid && (sel == 2);

    logic       head_a, en_a, busy_a, done_a, err_a;
    logic       head_b, en_b, busy_b, done_b, err_b;
    logic       head_c, en_c, busy_c, done_c, err_c;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b;
    logic [4:0] cnt_c;

    logic [3:0]  chain_a = '0;
    logic [19:0] chain_b = '0;
    logic [15:0] chain_c = '0;
    logic        inv_tail;
    int          hs_cnt = 0;
    int          en_cnt = 0;

    ccff_loader #(.WORD_W(8), .CHAIN_LEN(4), .VERIFY_EN(0)) dut_a (
        .prog_clk(clk), .pReset(rst), .start(start && sel == 0), .abort(abort && sel == 0),
        .word_if(bus_a), .ccff_head(head_a), .ccff_clk_en(en_a), .ccff_tail(chain_a[3]),
        .busy(busy_a), .done(done_a), .error(err_a), .bit_count(cnt_a));

    ccff_loader #(.WORD_W(8), .CHAIN_LEN(20), .VERIFY_EN(0)) dut_b (
        .prog_clk(clk), .pReset(rst), .start(start && sel == 1), .abort(abort && sel == 1),
        .word_if(bus_b), .ccff_head(head_b), .ccff_clk_en(en_b), .ccff_tail(chain_b[19]),
        .busy(busy_b), .done(done_b), .error(err_b), .bit_count(cnt_b));

    ccff_loader #(.WORD_W(8), .CHAIN_LEN(16), .VERIFY_EN(1)) dut_c (
        .prog_clk(clk), .pReset(rst), .start(start && sel == 2), .abort(abort && sel == 2),
        .word_if(bus_c), .ccff_head(head_c), .ccff_clk_en(en_c), .ccff_tail(chain_c[15] ^ inv_tail),
        .busy(busy_c), .done(done_c), .error(err_c), .bit_count(cnt_c));

    // Chain models: capture head on enabled edges, tail is the deepest flop.
    always @(posedge clk) begin
        if (en_a) chain_a <= {chain_a[2:0], head_a};
        if (en_b) chain_b <= {chain_b[18:0], head_b};
        if (en_c) chain_c <= {chain_c[14:0], head_c};
    end

    logic       m_ready, m_head, m_en, m_busy, m_done, m_err;
    logic [7:0] m_cnt;
    logic [19:0] m_chain;

    always_comb begin
        m_ready = 1'b0; m_head = 1'b0; m_en = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_cnt = '0; m_chain = '0;
        case (sel)
            0: begin
                m_ready = bus_a.word_ready; m_head = head_a; m_en = en_a;
                m_busy = busy_a; m_done = done_a; m_err = err_a;
                m_cnt = {5'b0, cnt_a}; m_chain = {16'b0, chain_a};
            end
            1: begin
                m_ready = bus_b.word_ready; m_head = head_b; m_en = en_b;
                m_busy = busy_b; m_done = done_b; m_err = err_b;
                m_cnt = {3'b0, cnt_b}; m_chain = chain_b;
            end
            default: begin
                m_ready = bus_c.word_ready; m_head = head_c; m_en = en_c;
                m_busy = busy_c; m_done = done_c; m_err = err_c;
                m_cnt = {3'b0, cnt_c}; m_chain = {4'b0, chain_c};
            end
        endcase
    end

    // Handshake and enabled-shift counters for the selected loader.
    always @(posedge clk) begin
        if (start) begin
            hs_cnt <= 0;
            en_cnt <= 0;
        end else begin
            if (word_valid && m_ready) hs_cnt <= hs_cnt + 1;
            if (m_en) en_cnt <= en_cnt + 1;
        end
    end

    // Fault injection: corrupt the 6th recirculated bit (16 load + 5).
    assign inv_tail = inject && (sel == 2) && (en_cnt == 21);

    typedef struct {
        int          s;
        logic [23:0] wp;
        int          n;
        bit          inj;
        int          exp_hs;
        int          exp_cnt;
        int          exp_lat;
        bit          exp_err;
        bit          chk_chain;
        logic [19:0] exp_chain;
    } vec_t;

    vec_t vecs[7];
    logic exp_q[$];
    bit   mon_on;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int len_of(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 20 : 16);
    endfunction

    task automatic run_load(input vec_t v);
        int lat;
        int wi;
        bit fin;
        int len;
        sel    = v.s;
        inject = v.inj;
        len    = len_of(v.s);
        exp_q.delete();
        for (int k = 0; k < len; k++) exp_q.push_back(v.wp[23-k]);
        if (v.s == 2)
            for (int k = 0; k < 16; k++) exp_q.push_back(v.wp[23-k] ^ (v.inj && k == 5));
        mon_on = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        fin = 1'b0;
        lat = -1;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (m_done || m_err) begin
                fin = 1'b1;
                lat = cyc;
            end else begin
                wi         = (hs_cnt < 3) ? hs_cnt : 0;
                word_valid = (hs_cnt < v.n);
                word_data  = v.wp[23-8*wi -: 8];
                @(negedge clk);
            end
        end
        word_valid = 1'b0;
        mon_on     = 1'b0;
        inject     = 1'b0;
        check("load_finished", 32'(fin), 32'd1);
        check("done", 32'(m_done), 32'd1);
        check("error", 32'(m_err), 32'(v.exp_err));
        check("busy_at_done", 32'(m_busy), 32'd0);
        check("bit_count_at_done", 32'(m_cnt), 32'(v.exp_cnt));
        check("handshakes", 32'(hs_cnt), 32'(v.exp_hs));
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("head_bits_left", 32'(exp_q.size()), 32'd0);
        if (v.chk_chain) check("chain_contents", 32'(m_chain), 32'(v.exp_chain));
    endtask

    initial begin
        logic e;
        bit   seen;

        rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
        word_data = '0; inject = 1'b0; sel = 0; mon_on = 1'b0;

        //         s  words        n inj hs cnt lat err chk chain
        vecs[0] = '{0, 24'hA00000, 1, 0, 1, 4,  5,  0, 1, 20'h0000A};
        vecs[1] = '{1, 24'h5AC3F0, 3, 0, 3, 20, 23, 0, 1, 20'h5AC3F};
        vecs[2] = '{2, 24'h123400, 2, 0, 2, 16, 34, 0, 1, 20'h01234};
        vecs[3] = '{2, 24'h123400, 2, 1, 2, 16, 34, 1, 0, 20'h00000};
        vecs[4] = '{0, 24'h5F0000, 1, 0, 1, 4,  5,  0, 1, 20'h00005};
        vecs[5] = '{1, 24'hFF0090, 3, 0, 3, 20, 23, 0, 1, 20'hFF009};
        vecs[6] = '{2, 24'hA5C300, 2, 0, 2, 16, 34, 0, 1, 20'h0A5C3};

        // Head-bit scoreboard: every enabled shift pops one expected bit.
        fork
            forever begin
                @(negedge clk);
                if (mon_on && m_en) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL head_extra_shift: got shift with head %0b expected no shift", m_head);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_head !== e) begin
                            n_fail++;
                            $display("FAIL head_bit: got %0b expected %0b (en_cnt %0d)", m_head, e, en_cnt);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ready", 32'(m_ready), 32'd0);
            check("rst_clk_en", 32'(m_en), 32'd0);
            check("rst_head", 32'(m_head), 32'd0);
            check("rst_busy", 32'(m_busy), 32'd0);
            check("rst_done", 32'(m_done), 32'd0);
            check("rst_error", 32'(m_err), 32'd0);
            check("rst_bit_count", 32'(m_cnt), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_load(vecs[i]);

        // Host stall in FETCH, then abort mid-SHIFT.
        sel = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_clk_en", 32'(m_en), 32'd0);
            check("stall_bit_count", 32'(m_cnt), 32'd0);
            check("stall_ready", 32'(m_ready), 32'd1);
            @(negedge clk);
        end
        word_valid = 1'b1;
        word_data  = 8'h12;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_en) seen = 1'b1;
        end
        word_valid = 1'b0;
        check("stall_shift_started", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        check("pre_abort_bit_count", 32'(m_cnt), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_error", 32'(m_err), 32'd1);
        check("abort_done", 32'(m_done), 32'd0);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_clk_en", 32'(m_en), 32'd0);
        check("abort_ready", 32'(m_ready), 32'd0);

        // Reset in the middle of VERIFY, then clean reloads.
        sel = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (en_cnt >= 20) begin
                seen = 1'b1;
            end else begin
                word_valid = (hs_cnt < 2);
                word_data  = (hs_cnt == 0) ? 8'h12 : 8'h34;
                @(negedge clk);
            end
        end
        word_valid = 1'b0;
        check("reached_verify", 32'(seen), 32'd1);
        check("verify_busy", 32'(m_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("vrst_ready", 32'(m_ready), 32'd0);
        check("vrst_clk_en", 32'(m_en), 32'd0);
        check("vrst_head", 32'(m_head), 32'd0);
        check("vrst_busy", 32'(m_busy), 32'd0);
        check("vrst_done", 32'(m_done), 32'd0);
        check("vrst_error", 32'(m_err), 32'd0);
        check("vrst_bit_count", 32'(m_cnt), 32'd0);
        run_load(vecs[2]);
        run_load(vecs[0]);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
